bram_vector_loader: RTL and testbench

Parametrised successor to the free-running BRAM-to-vector reader. It reads VLEN consecutive words of width DW from a synchronous block-RAM read port, starting at BASE_ADDR, into a shadow buffer. It then commits the whole vector to its output in a single cycle, so consumers never see a partially updated vector. Passes run either on a start/done handshake or back-to-back in continuous mode. The block sits between a PS-written BRAM and PL compute modules that take a flat vector input.

---
 rtl/bram_vector_loader_if.sv | 27 ++
 rtl/bram_vector_loader.sv | 158 +++++++++++++++
 tb/tb_bram_vector_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_vector_loader_if.sv
// Handshake and BRAM read-port bundle for bram_vector_loader.
// master = the loader itself, slave = the surrounding system (control, BRAM, consumers).
interface bram_vector_loader_if #(
  parameter int VLEN = 1,
  parameter int DW   = 32,
  parameter int AW   = 11
);
  logic                 start;
  logic                 stop;
  logic                 busy;
  logic                 done;
  logic                 vec_valid;
  logic [DW*VLEN-1:0]   vec;
  logic [AW-1:0]        mem_addr;
  logic                 mem_en;
  logic [DW-1:0]        mem_dout;

  modport master (
    input  start, stop, mem_dout,
    output busy, done, vec_valid, vec, mem_addr, mem_en
  );

  modport slave (
    output start, stop, mem_dout,
    input  busy, done, vec_valid, vec, mem_addr, mem_en
  );
endinterface

// File: rtl/bram_vector_loader.sv
// Reads VLEN consecutive BRAM words into a shadow buffer and commits them to vec in one cycle.
// Start-to-done latency VLEN+RD_LATENCY+1; continuous mode restarts right after each commit.
module bram_vector_loader #(
  parameter int VLEN       = 1,
  parameter int DW         = 32,
  parameter int AW         = 11,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_vector_loader_if.master io
);
  localparam int            IW   = $clog2(VLEN + 1);
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [IW-1:0] LAST = IW'(VLEN - 1);
  localparam bit            CONT = (CONTINUOUS != 0);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 mem_en_q, mem_en_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 vec_valid_q, vec_valid_d;
  logic                 stop_q, stop_d;
  logic                 arm_q, arm_d;
  logic [DW*VLEN-1:0]   vec_q, vec_d;
  logic [DW*VLEN-1:0]   shadow_q, shadow_d;
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [IW-1:0]        pi_q [RD_LATENCY];
  logic [IW-1:0]        pi_d [RD_LATENCY];
  logic                 start_pass;
  logic                 last_cap;

  assign last_cap = pv_q[RD_LATENCY-1] && (pi_q[RD_LATENCY-1] == LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vec_valid_d = vec_valid_q;
    stop_d      = stop_q;
    arm_d       = arm_q;
    vec_d       = vec_q;
    shadow_d    = shadow_q;
    start_pass  = 1'b0;

    // Valid/index pipeline follows each issued read until its data returns.
    pv_d[0] = mem_en_q;
    pi_d[0] = idx_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pv_d[k] = pv_q[k-1];
      pi_d[k] = pi_q[k-1];
    end
    if (pv_q[RD_LATENCY-1]) begin
      shadow_d[DW*pi_q[RD_LATENCY-1] +: DW] = io.mem_dout;
    end

    if (CONT && busy_q && io.stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // arm_q gives the post-reset auto-start; a stopped loader waits for start.
        if (io.start || (CONT && arm_q && !stop_q)) begin
          start_pass = 1'b1;
        end
      end
      READ: begin
        if (idx_q == LAST) begin
          state_d  = DRAIN;
          mem_en_d = 1'b0;
        end else begin
          idx_d      = idx_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last_cap) begin
          state_d = COMMIT;
          done_d  = 1'b1;
        end
      end
      COMMIT: begin
        vec_d       = shadow_q;
        vec_valid_d = 1'b1;
        if (CONT && !stop_q) begin
          start_pass = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          arm_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_pass) begin
      state_d    = READ;
      busy_d     = 1'b1;
      mem_en_d   = 1'b1;
      mem_addr_d = BASE;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      stop_q      <= 1'b0;
      arm_q       <= 1'b1;
      vec_q       <= '0;
      shadow_q    <= '0;
      pv_q        <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pi_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vec_valid_q <= vec_valid_d;
      stop_q      <= stop_d;
      arm_q       <= arm_d;
      vec_q       <= vec_d;
      shadow_q    <= shadow_d;
      pv_q        <= pv_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pi_q[k] <= pi_d[k];
      end
    end
  end

  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.vec_valid = vec_valid_q;
  assign io.vec       = vec_q;
  assign io.mem_addr  = mem_addr_q;
  assign io.mem_en    = mem_en_q;
endmodule

// File: tb/tb_bram_vector_loader.sv
// Bench for bram_vector_loader: four configurations (latency 1/3, address wrap, continuous)
// driven from a pass table plus hand-written hold-start, reset and stop sequences.
module tb_bram_vector_loader;
  logic clk = 1'b0;
  logic rst;
  logic rst_d;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_vector_loader_if #(.VLEN(4), .DW(32), .AW(11)) io_a ();
  bram_vector_loader_if #(.VLEN(4), .DW(32), .AW(11)) io_b ();
  bram_vector_loader_if #(.VLEN(4), .DW(32), .AW(4))  io_c ();
  bram_vector_loader_if #(.VLEN(2), .DW(32), .AW(11)) io_d ();

  bram_vector_loader #(.VLEN(4), .DW(32), .AW(11), .BASE_ADDR(0), .RD_LATENCY(1), .CONTINUOUS(0))
    dut_a (.clk(clk), .rst(rst), .io(io_a));
  bram_vector_loader #(.VLEN(4), .DW(32), .AW(11), .BASE_ADDR(0), .RD_LATENCY(3), .CONTINUOUS(0))
    dut_b (.clk(clk), .rst(rst), .io(io_b));
  bram_vector_loader #(.VLEN(4), .DW(32), .AW(4), .BASE_ADDR(14), .RD_LATENCY(1), .CONTINUOUS(0))
    dut_c (.clk(clk), .rst(rst), .io(io_c));
  bram_vector_loader #(.VLEN(2), .DW(32), .AW(11), .BASE_ADDR(0), .RD_LATENCY(1), .CONTINUOUS(1))
    dut_d (.clk(clk), .rst(rst_d), .io(io_d));

  // BRAM models
  logic [31:0] mem_a [2048];
  logic [31:0] mem_b [2048];
  logic [31:0] mem_c [16];
  logic [31:0] mem_d [2048];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) if (io_a.mem_en) io_a.mem_dout <= mem_a[io_a.mem_addr];
  always @(posedge clk) if (io_c.mem_en) io_c.mem_dout <= mem_c[io_c.mem_addr];
  always @(posedge clk) if (io_d.mem_en) io_d.mem_dout <= mem_d[io_d.mem_addr];
  always @(posedge clk) begin
    b_p1          <= mem_b[io_b.mem_addr];
    b_p2          <= b_p1;
    io_b.mem_dout <= b_p2;
  end

  typedef struct {
    int           sel;
    logic [127:0] words;
    bit           chg;
    logic [127:0] exp;
    string        tag;
  } rec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  function automatic int base_of(input int sel);
    return (sel == 2) ? 14 : 0;
  endfunction

  function automatic int msk_of(input int sel);
    return (sel == 2) ? 15 : 2047;
  endfunction

  task automatic sample(input int sel, output logic en, output logic [10:0] a, output logic dn,
                        output logic bz, output logic vv, output logic [127:0] v);
    case (sel)
      0: begin en = io_a.mem_en; a = io_a.mem_addr; dn = io_a.done; bz = io_a.busy;
               vv = io_a.vec_valid; v = io_a.vec; end
      1: begin en = io_b.mem_en; a = io_b.mem_addr; dn = io_b.done; bz = io_b.busy;
               vv = io_b.vec_valid; v = io_b.vec; end
      2: begin en = io_c.mem_en; a = 11'(io_c.mem_addr); dn = io_c.done; bz = io_c.busy;
               vv = io_c.vec_valid; v = io_c.vec; end
      default: begin en = io_d.mem_en; a = io_d.mem_addr; dn = io_d.done; bz = io_d.busy;
               vv = io_d.vec_valid; v = {64'd0, io_d.vec}; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic val);
    case (sel)
      0: io_a.start = val;
      1: io_b.start = val;
      2: io_c.start = val;
      default: io_d.start = val;
    endcase
  endtask

  task automatic wr(input int sel, input int i, input logic [31:0] val);
    case (sel)
      0: mem_a[11'(i)] = val;
      1: mem_b[11'(i)] = val;
      2: mem_c[4'(14 + i)] = val;
      default: mem_d[11'(i)] = val;
    endcase
  endtask

  // One start-pulsed pass on a VLEN=4 loader; expected vec goes through the scoreboard queue.
  task automatic run_pass(input int sel, input logic [127:0] exp_vec, input bit chg,
                          input string tag, output int done_cyc);
    int lat = lat_of(sel);
    int kmax = 4 + lat + 3;
    logic [15:0] en_m, dn_m, bz_m, en_x, dn_x, bz_x;
    logic [63:0] adr_seq, adr_x;
    logic [127:0] prev, v, e;
    logic en, dn, bz, vv;
    logic [10:0] a;
    bit early;
    sample(sel, en, a, dn, bz, vv, prev);
    en_m = '0; dn_m = '0; bz_m = '0; adr_seq = '0; early = 1'b0; done_cyc = -1;
    exp_q.push_back(exp_vec);
    set_start(sel, 1'b1);
    for (int k = 1; k <= kmax; k++) begin
      tick();
      if (k == 1) set_start(sel, 1'b0);
      if (chg && k == 2) begin
        wr(sel, 0, 32'h0000aaaa);
        wr(sel, 3, 32'h0000bbbb);
      end
      sample(sel, en, a, dn, bz, vv, v);
      en_m[k] = en;
      dn_m[k] = dn;
      bz_m[k] = bz;
      if (en) adr_seq = {adr_seq[47:0], 5'd0, a};
      if (dn && done_cyc < 0) done_cyc = cyc;
      if (k <= 4 + lat + 1 && v !== prev) early = 1'b1;
    end
    en_x = 16'h001e;
    dn_x = 16'(1 << (4 + lat + 1));
    bz_x = 16'(((1 << (4 + lat + 1)) - 1) << 1);
    adr_x = '0;
    for (int i = 0; i < 4; i++) adr_x = {adr_x[47:0], 16'((base_of(sel) + i) & msk_of(sel))};
    check({tag, "_mem_en"}, en_m, en_x);
    check({tag, "_done"}, dn_m, dn_x);
    check({tag, "_busy"}, bz_m, bz_x);
    check({tag, "_addr"}, adr_seq, adr_x);
    check({tag, "_vec_early"}, early, 1'b0);
    e = exp_q.pop_front();
    check({tag, "_vec"}, v, e);
    check({tag, "_vec_valid"}, vv, 1'b1);
  endtask

  initial begin
    rec_t recs [4];
    int dc, ndone, nen, nbad, nact;
    logic en, dn, bz, vv, pdn;
    logic [10:0] a;
    logic [127:0] v;
    logic [31:0] en_m, dn_m, bz_m;

    recs[0] = '{0, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0,
                {32'h44, 32'h33, 32'h22, 32'h11}, "lat1"};
    recs[1] = '{0, {32'h12345678, 32'hffffffff, 32'h0, 32'hdeadbeef}, 1'b1,
                {32'h0000bbbb, 32'hffffffff, 32'h0, 32'hdeadbeef}, "lat1_chg"};
    recs[2] = '{1, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0,
                {32'h44, 32'h33, 32'h22, 32'h11}, "lat3"};
    recs[3] = '{2, {32'd1, 32'd0, 32'd15, 32'd14}, 1'b0,
                {32'd1, 32'd0, 32'd15, 32'd14}, "wrap"};

    rst = 1'b1; rst_d = 1'b1;
    io_a.start = 1'b0; io_b.start = 1'b0; io_c.start = 1'b0; io_d.start = 1'b0;
    io_a.stop = 1'b0;  io_b.stop = 1'b0;  io_c.stop = 1'b0;  io_d.stop = 1'b0;
    for (int i = 0; i < 16; i++) mem_c[i] = 32'(i);

    repeat (3) tick();
    sample(0, en, a, dn, bz, vv, v);
    check("reset_state", {en, a, dn, bz, vv, v}, '0);
    rst = 1'b0;
    while (cyc < 10) tick();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) wr(recs[r].sel, i, recs[r].words[32*i +: 32]);
      run_pass(recs[r].sel, recs[r].exp, recs[r].chg, recs[r].tag, dc);
      if (r == 0) check("first_done_cycle", 128'(dc), 128'd16);
      repeat (2) tick();
    end

    // start held for 20 cycles: passes of 7 cycles, each relaunched from IDLE
    ndone = 0; nen = 0; nbad = 0; pdn = 1'b0;
    io_a.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 20) io_a.start = 1'b0;
      sample(0, en, a, dn, bz, vv, v);
      if (dn) ndone++;
      if (en) nen++;
      if (pdn && bz) nbad++;
      pdn = dn;
    end
    check("hold_done_count", 128'(ndone), 128'd3);
    check("hold_mem_en_count", 128'(nen), 128'd12);
    check("hold_busy_after_done", 128'(nbad), 128'd0);

    // reset in cycle N+2 together with a start that must be dropped
    repeat (2) tick();
    io_a.start = 1'b1;
    tick();
    io_a.start = 1'b0;
    tick();
    rst = 1'b1;
    io_a.start = 1'b1;
    tick();
    rst = 1'b0;
    io_a.start = 1'b0;
    sample(0, en, a, dn, bz, vv, v);
    check("rst_mid_pass", {dn, bz, vv, v}, '0);
    nact = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      sample(0, en, a, dn, bz, vv, v);
      if (en || dn || bz) nact++;
    end
    check("rst_start_dropped", 128'(nact), 128'd0);
    for (int i = 0; i < 4; i++) wr(0, i, 32'h5a5a0001 + 32'(i));
    run_pass(0, {32'h5a5a0004, 32'h5a5a0003, 32'h5a5a0002, 32'h5a5a0001}, 1'b0, "after_rst", dc);

    // continuous mode: auto-start after reset release, period 4
    mem_d[0] = 32'ha0; mem_d[1] = 32'hb1;
    rst_d = 1'b0;
    en_m = '0; dn_m = '0; bz_m = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      sample(3, en, a, dn, bz, vv, v);
      en_m[k] = en; dn_m[k] = dn; bz_m[k] = bz;
    end
    check("cont_mem_en", en_m, 32'h00006666);
    check("cont_done", dn_m, 32'h00011110);
    check("cont_busy", bz_m, 32'h0001fffe);
    check("cont_vec", {vv, v}, {1'b1, 64'd0, 32'hb1, 32'ha0});
    mem_d[1] = 32'hc2;
    repeat (4) tick();
    sample(3, en, a, dn, bz, vv, v);
    check("cont_vec_hold", {dn, v}, {1'b1, 64'd0, 32'hb1, 32'ha0});
    tick();
    sample(3, en, a, dn, bz, vv, v);
    check("cont_vec_new", v, {64'd0, 32'hc2, 32'ha0});
    tick();
    io_d.stop = 1'b1;
    ndone = 0; nact = 0;
    for (int k = 23; k <= 40; k++) begin
      tick();
      if (k == 23) io_d.stop = 1'b0;
      sample(3, en, a, dn, bz, vv, v);
      if (dn) ndone++;
      if (k >= 26 && (en || bz || dn)) nact++;
    end
    check("stop_done_count", 128'(ndone), 128'd1);
    check("stop_idle", 128'(nact), 128'd0);
    check("stop_vec_valid", vv, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
